// File: rtl/mem_stage_ext.sv
// ---------------------------------------------------------------------------
// mem_stage_ext
// Memory-access pipeline stage between EX and WB. Latches the EX->MEM bundle
// under stall/bubble control, tracks a variable-latency data-SRAM response
// (requesting a pipeline stall while it waits), extracts and extends
// sub-word load data for 32- or 64-bit datapaths, and forwards the result to
// WB and to ID.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   stall[STALL_W]                pipeline stall bus (1 = stop)
//   ex_*                          EX->MEM bundle (pc, memory access info,
//                                 GPR writeback intent, HI/LO pass-through)
//   data_sram_rdata/rvalid        SRAM read data and response/ack
//   stallreq_mem                  stage requests a pipeline stall
//   wb_*                          writeback bundle to WB
//   fwd_*                         forwarding bundle to ID
//   fwd_load_pending              fwd_rf_wdata not yet valid
// ---------------------------------------------------------------------------
module mem_stage_ext #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OFS_W   = $clog2(DATA_W / 8),
  parameter int unsigned RA_W    = 5,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [31:0]        ex_pc,
  input  logic               ex_mem_en,
  input  logic               ex_mem_store,
  input  logic [2:0]         ex_ld_type,
  input  logic [OFS_W-1:0]   ex_addr_ofs,
  input  logic               ex_rf_we,
  input  logic [RA_W-1:0]    ex_rf_waddr,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [1:0]         ex_hilo_we,
  input  logic [31:0]        ex_hi,
  input  logic [31:0]        ex_lo,
  input  logic [DATA_W-1:0]  data_sram_rdata,
  input  logic               data_sram_rvalid,
  output logic               stallreq_mem,
  output logic [31:0]        wb_pc,
  output logic               wb_rf_we,
  output logic [RA_W-1:0]    wb_rf_waddr,
  output logic [DATA_W-1:0]  wb_rf_wdata,
  output logic [1:0]         wb_hilo_we,
  output logic [31:0]        wb_hi,
  output logic [31:0]        wb_lo,
  output logic               fwd_rf_we,
  output logic [RA_W-1:0]    fwd_rf_waddr,
  output logic [DATA_W-1:0]  fwd_rf_wdata,
  output logic               fwd_load_pending
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Load type encoding
  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;
  localparam logic [2:0] LT_LWU = 3'b101;
  localparam logic [2:0] LT_LD  = 3'b110;

  // Lane masks: halfword ignores ofs[0], word ignores ofs[1:0]
  localparam logic [OFS_W-1:0] HALF_MASK = ~OFS_W'(1);
  localparam logic [OFS_W-1:0] WORD_MASK = ~OFS_W'(3);

  typedef struct packed {
    logic [31:0]       pc;
    logic              mem_en;
    logic              mem_store;
    logic [2:0]        ld_type;
    logic [OFS_W-1:0]  ofs;
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] result;
    logic [1:0]        hilo_we;
    logic [31:0]       hi;
    logic [31:0]       lo;
  } stage_t;

  stage_t            stage_q, stage_d;
  stage_t            ex_bundle;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] ldbuf_q, ldbuf_d;

  logic              wait_hold;
  logic              bubble;
  logic              capture;
  logic              stallreq_c;

  logic [DATA_W-1:0] raw_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       word_v;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] rf_wdata;

  // Only bits STAGE and STAGE+1 of the stall bus matter here
  logic              unused_stall;
  assign unused_stall = ^stall;

  assign ex_bundle = '{
    pc:        ex_pc,
    mem_en:    ex_mem_en,
    mem_store: ex_mem_store,
    ld_type:   ex_ld_type,
    ofs:       ex_addr_ofs,
    rf_we:     ex_rf_we,
    rf_waddr:  ex_rf_waddr,
    result:    ex_result,
    hilo_we:   ex_hilo_we,
    hi:        ex_hi,
    lo:        ex_lo
  };

  // An outstanding access pins the stage regardless of the stall bus
  assign wait_hold  = (state_q == S_WAIT) & ~data_sram_rvalid;
  assign bubble     = stall[STAGE] & ~stall[STAGE+1];
  assign capture    = ~stall[STAGE];
  assign stallreq_c = wait_hold;

  // Next-state: stage register, FSM and load buffer
  always_comb begin
    stage_d = stage_q;
    state_d = state_q;
    ldbuf_d = ldbuf_q;

    // Response latched even if the stage advances in the same cycle
    if ((state_q == S_WAIT) && data_sram_rvalid) begin
      ldbuf_d = data_sram_rdata;
      state_d = S_DONE;
    end

    if (wait_hold) begin
      stage_d = stage_q;
      state_d = S_WAIT;
    end else if (bubble) begin
      stage_d = '0;
      state_d = S_IDLE;
    end else if (capture) begin
      stage_d = ex_bundle;
      state_d = ex_mem_en ? S_WAIT : S_IDLE;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      state_q <= S_IDLE;
      ldbuf_q <= '0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      ldbuf_q <= ldbuf_d;
    end
  end

  // Raw data is live from the SRAM while waiting, buffered afterwards
  assign raw_data = (state_q == S_WAIT) ? data_sram_rdata : ldbuf_q;
  assign byte_v   = 8'(raw_data >> {stage_q.ofs, 3'b000});
  assign half_v   = 16'(raw_data >> {stage_q.ofs & HALF_MASK, 3'b000});
  assign word_v   = 32'(raw_data >> {stage_q.ofs & WORD_MASK, 3'b000});

  // Little-endian lane extraction with sign/zero extension
  always_comb begin
    ld_data = raw_data;
    case (stage_q.ld_type)
      LT_LB:   ld_data = DATA_W'($signed(byte_v));
      LT_LBU:  ld_data = DATA_W'(byte_v);
      LT_LH:   ld_data = DATA_W'($signed(half_v));
      LT_LHU:  ld_data = DATA_W'(half_v);
      LT_LW:   ld_data = DATA_W'($signed(word_v));
      LT_LWU:  ld_data = DATA_W'(word_v);
      LT_LD:   ld_data = raw_data;
      default: ld_data = raw_data;
    endcase
  end

  assign rf_wdata = (stage_q.mem_en & ~stage_q.mem_store) ? ld_data : stage_q.result;

  // Output bundles
  assign stallreq_mem     = stallreq_c;
  assign wb_pc            = stage_q.pc;
  assign wb_rf_we         = stage_q.rf_we & ~stallreq_c;
  assign wb_rf_waddr      = stage_q.rf_waddr;
  assign wb_rf_wdata      = rf_wdata;
  assign wb_hilo_we       = stage_q.hilo_we & {2{~stallreq_c}};
  assign wb_hi            = stage_q.hi;
  assign wb_lo            = stage_q.lo;
  assign fwd_rf_we        = stage_q.rf_we;
  assign fwd_rf_waddr     = stage_q.rf_waddr;
  assign fwd_rf_wdata     = rf_wdata;
  assign fwd_load_pending = stallreq_c & stage_q.rf_we;

endmodule

// File: tb/tb_mem_stage_ext.sv
module tb_mem_stage_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [31:0] ex_pc;
  logic        ex_mem_en, ex_mem_store;
  logic [2:0]  ex_ld_type;
  logic [2:0]  ex_addr_ofs;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [63:0] ex_result;
  logic [1:0]  ex_hilo_we;
  logic [31:0] ex_hi, ex_lo;
  logic [63:0] rdata;
  logic        rvalid;

  // 32-bit instance outputs
  logic        a_sr, a_we, a_fwe, a_pend;
  logic [31:0] a_pc, a_wd, a_fwd, a_hi, a_lo;
  logic [4:0]  a_wa, a_fwa;
  logic [1:0]  a_hwe;
  // 64-bit instance outputs
  logic        b_sr, b_we, b_fwe, b_pend;
  logic [31:0] b_pc, b_hi, b_lo;
  logic [63:0] b_wd, b_fwd;
  logic [4:0]  b_wa, b_fwa;
  logic [1:0]  b_hwe;

  always #5 clk = ~clk;

  mem_stage_ext #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .stall(stall), .ex_pc(ex_pc),
    .ex_mem_en(ex_mem_en), .ex_mem_store(ex_mem_store), .ex_ld_type(ex_ld_type),
    .ex_addr_ofs(ex_addr_ofs[1:0]), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result[31:0]), .ex_hilo_we(ex_hilo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .data_sram_rdata(rdata[31:0]), .data_sram_rvalid(rvalid),
    .stallreq_mem(a_sr), .wb_pc(a_pc), .wb_rf_we(a_we), .wb_rf_waddr(a_wa),
    .wb_rf_wdata(a_wd), .wb_hilo_we(a_hwe), .wb_hi(a_hi), .wb_lo(a_lo),
    .fwd_rf_we(a_fwe), .fwd_rf_waddr(a_fwa), .fwd_rf_wdata(a_fwd),
    .fwd_load_pending(a_pend)
  );

  mem_stage_ext #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .stall(stall), .ex_pc(ex_pc),
    .ex_mem_en(ex_mem_en), .ex_mem_store(ex_mem_store), .ex_ld_type(ex_ld_type),
    .ex_addr_ofs(ex_addr_ofs), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result), .ex_hilo_we(ex_hilo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .data_sram_rdata(rdata), .data_sram_rvalid(rvalid),
    .stallreq_mem(b_sr), .wb_pc(b_pc), .wb_rf_we(b_we), .wb_rf_waddr(b_wa),
    .wb_rf_wdata(b_wd), .wb_hilo_we(b_hwe), .wb_hi(b_hi), .wb_lo(b_lo),
    .fwd_rf_we(b_fwe), .fwd_rf_waddr(b_fwa), .fwd_rf_wdata(b_fwd),
    .fwd_load_pending(b_pend)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic        mem_en;
    logic        store;
    logic [2:0]  lt;
    logic [2:0]  ofs;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [63:0] result;
    logic [1:0]  hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } bundle_t;

  bundle_t     m_cur;      // instruction currently held by the stage
  logic        m_wait;     // its memory response is still outstanding
  logic [63:0] m_buf;      // last response received

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cur  = '0;
    m_wait = 1'b0;
    m_buf  = '0;
  endtask

  // Advance the model across one rising edge using the inputs seen there
  task automatic model_step();
    if (rst) model_reset();
    else if (!(m_wait && !rvalid)) begin
      if (m_wait) begin
        m_buf  = rdata;
        m_wait = 1'b0;
      end
      if (stall[3] && !stall[4]) m_cur = '0;
      else if (!stall[3]) begin
        m_cur = '{pc: ex_pc, mem_en: ex_mem_en, store: ex_mem_store, lt: ex_ld_type,
                  ofs: ex_addr_ofs, rf_we: ex_rf_we, waddr: ex_rf_waddr, result: ex_result,
                  hilo_we: ex_hilo_we, hi: ex_hi, lo: ex_lo};
        m_wait = ex_mem_en;
      end
    end
  endtask

  function automatic logic [63:0] model_ext(int w, logic [2:0] lt, logic [2:0] ofs,
                                            logic [63:0] raw_in);
    logic [63:0] mask, raw, v;
    int sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    raw  = raw_in & mask;
    case (lt)
      3'b001, 3'b010: begin
        sh = 8 * int'(ofs);
        v  = (raw >> sh) & 64'hFF;
        if (lt == 3'b001 && v[7]) v = v | ~64'hFF;
      end
      3'b011, 3'b100: begin
        sh = 8 * (int'(ofs) & ~1);
        v  = (raw >> sh) & 64'hFFFF;
        if (lt == 3'b011 && v[15]) v = v | ~64'hFFFF;
      end
      3'b000, 3'b101: begin
        sh = (w == 64) ? 8 * (int'(ofs) & 4) : 0;
        v  = (raw >> sh) & 64'hFFFF_FFFF;
        if (lt == 3'b000 && v[31]) v = v | ~64'hFFFF_FFFF;
      end
      default: v = raw;
    endcase
    return v & mask;
  endfunction

  function automatic logic [63:0] exp_wdata(int w);
    logic [63:0] mask;
    logic [2:0]  ofs;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ofs  = (w == 64) ? m_cur.ofs : (m_cur.ofs & 3'b011);
    if (m_cur.mem_en && !m_cur.store)
      return model_ext(w, m_cur.lt, ofs, m_wait ? rdata : m_buf);
    return m_cur.result & mask;
  endfunction

  // Compare process: every output of both instances, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_sr;
      e_sr = m_wait & ~rvalid;
      chk("a.stallreq", 64'(a_sr), 64'(e_sr));
      chk("a.wb_pc", 64'(a_pc), 64'(m_cur.pc));
      chk("a.wb_rf_we", 64'(a_we), 64'(m_cur.rf_we & ~e_sr));
      chk("a.wb_rf_waddr", 64'(a_wa), 64'(m_cur.waddr));
      if (!(m_cur.mem_en && !m_cur.store && m_cur.lt == 3'b110)) begin
        chk("a.wb_rf_wdata", 64'(a_wd), exp_wdata(32));
        chk("a.fwd_rf_wdata", 64'(a_fwd), exp_wdata(32));
      end
      chk("a.wb_hilo_we", 64'(a_hwe), 64'(m_cur.hilo_we & {2{~e_sr}}));
      chk("a.wb_hi", 64'(a_hi), 64'(m_cur.hi));
      chk("a.wb_lo", 64'(a_lo), 64'(m_cur.lo));
      chk("a.fwd_rf_we", 64'(a_fwe), 64'(m_cur.rf_we));
      chk("a.fwd_rf_waddr", 64'(a_fwa), 64'(m_cur.waddr));
      chk("a.fwd_load_pending", 64'(a_pend), 64'(e_sr & m_cur.rf_we));

      chk("b.stallreq", 64'(b_sr), 64'(e_sr));
      chk("b.wb_pc", 64'(b_pc), 64'(m_cur.pc));
      chk("b.wb_rf_we", 64'(b_we), 64'(m_cur.rf_we & ~e_sr));
      chk("b.wb_rf_waddr", 64'(b_wa), 64'(m_cur.waddr));
      chk("b.wb_rf_wdata", b_wd, exp_wdata(64));
      chk("b.fwd_rf_wdata", b_fwd, exp_wdata(64));
      chk("b.wb_hilo_we", 64'(b_hwe), 64'(m_cur.hilo_we & {2{~e_sr}}));
      chk("b.wb_hi", 64'(b_hi), 64'(m_cur.hi));
      chk("b.wb_lo", 64'(b_lo), 64'(m_cur.lo));
      chk("b.fwd_rf_we", 64'(b_fwe), 64'(m_cur.rf_we));
      chk("b.fwd_rf_waddr", 64'(b_fwa), 64'(m_cur.waddr));
      chk("b.fwd_load_pending", 64'(b_pend), 64'(e_sr & m_cur.rf_we));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_nop();
    stall        = 6'b000000;
    ex_pc        = '0;
    ex_mem_en    = 1'b0;
    ex_mem_store = 1'b0;
    ex_ld_type   = '0;
    ex_addr_ofs  = '0;
    ex_rf_we     = 1'b0;
    ex_rf_waddr  = '0;
    ex_result    = '0;
    ex_hilo_we   = '0;
    ex_hi        = '0;
    ex_lo        = '0;
    rvalid       = 1'b0;
  endtask

  task automatic issue_load(input logic [2:0] lt, input logic [2:0] ofs,
                            input logic [4:0] wa, input logic [31:0] pc);
    set_nop();
    ex_pc       = pc;
    ex_mem_en   = 1'b1;
    ex_ld_type  = lt;
    ex_addr_ofs = ofs;
    ex_rf_we    = 1'b1;
    ex_rf_waddr = wa;
    ex_result   = {$urandom, $urandom};
  endtask

  // Capture a load, answer it in the next cycle, return both instances' data
  task automatic load_zw(input logic [2:0] lt, input logic [2:0] ofs, input logic [63:0] rd,
                         output logic [63:0] r32, output logic [63:0] r64);
    issue_load(lt, ofs, 5'd3, 32'h0000_0040);
    tick();
    set_nop();
    rvalid = 1'b1;
    rdata  = rd;
    @(negedge clk);
    r32 = 64'(a_wd);
    r64 = b_wd;
    tick();
  endtask

  logic [2:0]  sw_lt  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
  logic [2:0]  sw_ofs [4] = '{3'd2, 3'd2, 3'd2, 3'd0};
  logic [63:0] sw_exp [4] = '{64'hFFFF_FFFF, 64'h0000_00FF, 64'hFFFF_80FF, 64'h0000_7F01};
  string       sw_nm  [4] = '{"LB ofs2", "LBU ofs2", "LH ofs2", "LHU ofs0"};
  logic [2:0]  d_lt   [3] = '{3'b000, 3'b101, 3'b110};
  logic [2:0]  d_ofs  [3] = '{3'd4, 3'd4, 3'd0};
  logic [63:0] d_exp  [3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_FFFF_FFFE,
                              64'hFFFF_FFFE_0000_0001};
  string       d_nm   [3] = '{"LW64 ofs4", "LWU64 ofs4", "LD64"};

  initial begin
    logic [63:0] r32, r64;
    rst   = 1'b1;
    rdata = '0;
    set_nop();
    model_reset();
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst wb_pc", 64'(a_pc), 64'h0);
    chk("rst stallreq", 64'(b_sr), 64'h0);
    chk("rst wb_rf_wdata", b_wd, 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Zero-wait LW
    issue_load(3'b000, 3'd0, 5'd8, 32'h0000_0100);
    @(negedge clk);
    chk("zw pre stallreq", 64'(a_sr), 64'h0);
    tick();
    set_nop();
    rvalid = 1'b1;
    rdata  = 64'h0000_0000_8000_00F0;
    @(negedge clk);
    chk("zw stallreq", 64'(a_sr), 64'h0);
    chk("zw wb_rf_we", 64'(a_we), 64'h1);
    chk("zw wb_rf_waddr", 64'(a_wa), 64'd8);
    chk("zw wb_rf_wdata", 64'(a_wd), 64'h8000_00F0);
    tick();

    // Sub-word loads, 32-bit datapath
    for (int i = 0; i < 4; i++) begin
      load_zw(sw_lt[i], sw_ofs[i], 64'h0000_0000_80FF_7F01, r32, r64);
      chk(sw_nm[i], r32, sw_exp[i]);
    end

    // Three-cycle response; stall[3] stays 0 but the stage must hold
    issue_load(3'b000, 3'd0, 5'd9, 32'h0000_0200);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_nop();
      ex_pc = $urandom;
      @(negedge clk);
      chk("slow stallreq", 64'(a_sr), 64'h1);
      chk("slow load_pending", 64'(a_pend), 64'h1);
      chk("slow wb_rf_we", 64'(a_we), 64'h0);
      chk("slow wb_pc held", 64'(a_pc), 64'h200);
      tick();
    end
    set_nop();
    rvalid = 1'b1;
    rdata  = 64'h0000_0000_1234_5678;
    @(negedge clk);
    chk("slow end stallreq", 64'(a_sr), 64'h0);
    chk("slow end wb_rf_we", 64'(a_we), 64'h1);
    chk("slow end wdata", 64'(a_wd), 64'h1234_5678);
    tick();

    // 64-bit word and doubleword loads
    for (int i = 0; i < 3; i++) begin
      load_zw(d_lt[i], d_ofs[i], 64'hFFFF_FFFE_0000_0001, r32, r64);
      chk(d_nm[i], r64, d_exp[i]);
    end

    // Bubble after an ALU op with writeback and HI/LO
    set_nop();
    ex_pc = 32'h0000_0300; ex_rf_we = 1'b1; ex_rf_waddr = 5'd12;
    ex_result = 64'h1111_2222_3333_4444; ex_hilo_we = 2'b11; ex_hi = 32'h5; ex_lo = 32'h6;
    tick();
    stall = 6'b001000;
    tick();
    stall = 6'b011000;
    @(negedge clk);
    chk("bubble wb_pc", 64'(b_pc), 64'h0);
    chk("bubble wb_rf_we", 64'(b_we), 64'h0);
    chk("bubble wdata", b_wd, 64'h0);
    chk("bubble hilo_we", 64'(b_hwe), 64'h0);
    chk("bubble fwd_rf_we", 64'(b_fwe), 64'h0);
    tick();

    // Response arrives under an external hold, then stays buffered
    issue_load(3'b000, 3'd0, 5'd10, 32'h0000_0400);
    tick();
    set_nop();
    stall  = 6'b011000;
    rvalid = 1'b1;
    rdata  = 64'hCAFE_F00D_1122_3344;
    @(negedge clk);
    chk("hold resp a", 64'(a_wd), 64'h1122_3344);
    tick();
    rvalid = 1'b0;
    rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    chk("hold done a", 64'(a_wd), 64'h1122_3344);
    chk("hold done b", b_wd, 64'h1122_3344);
    chk("hold done stallreq", 64'(b_sr), 64'h0);
    tick();
    rvalid = 1'b1;
    rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk);
    chk("hold stray b", b_wd, 64'h1122_3344);
    tick();

    // Reset during WAIT, then a stray response
    issue_load(3'b001, 3'd1, 5'd11, 32'h0000_0500);
    tick();
    set_nop();
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst stallreq", 64'(a_sr), 64'h0);
    chk("midrst wb_pc", 64'(a_pc), 64'h0);
    chk("midrst pending", 64'(b_pend), 64'h0);
    tick();
    rst    = 1'b0;
    stall  = 6'b011000;
    rvalid = 1'b1;
    rdata  = 64'h0000_0000_0000_0055;
    @(negedge clk);
    chk("stray stallreq", 64'(a_sr), 64'h0);
    chk("stray wb_rf_we", 64'(a_we), 64'h0);
    chk("stray wdata", 64'(a_wd), 64'h0);
    tick();
    set_nop();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ex_pc        = $urandom;
      ex_mem_en    = ($urandom_range(0, 1) == 1);
      ex_mem_store = ex_mem_en && ($urandom_range(0, 3) == 0);
      ex_ld_type   = 3'($urandom_range(0, 5));
      ex_addr_ofs  = 3'($urandom);
      ex_rf_we     = ($urandom_range(0, 3) != 0);
      ex_rf_waddr  = 5'($urandom);
      ex_result    = {$urandom, $urandom};
      ex_hilo_we   = 2'($urandom);
      ex_hi        = $urandom;
      ex_lo        = $urandom;
      stall        = 6'b000000;
      stall[3]     = ($urandom_range(0, 3) == 0);
      stall[4]     = ($urandom_range(0, 3) == 0);
      rvalid       = ($urandom_range(0, 1) == 1);
      rdata        = {$urandom, $urandom};
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 255) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      tick();
    end

    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_ext.md
# mem_stage_ext

Parametrised memory-access pipeline stage sitting between EX and WB in the in-order integer pipeline. It latches the EX→MEM bundle under stall/bubble control and tracks a data-SRAM response that may take a variable number of cycles, raising a stall request while it waits. It extracts and extends sub-word load data for 32- or 64-bit datapaths. It forwards the result to WB and to ID, and tells ID when a load result is not yet available.

## Interface
Parameters:
- DATA_W, 32: datapath/SRAM width; legal values 32 or 64
- OFS_W, $clog2(DATA_W/8): byte-offset width
- RA_W, 5: register-file address width
- STALL_W, 6: stall bus width
- STAGE, 3: stall bit that controls this stage's input register; bit STAGE+1 controls the next stage

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall  in  STALL_W  pipeline stall bus, 1 = Stop
- ex_pc  in  32  instruction PC
- ex_mem_en  in  1  instruction accesses data SRAM
- ex_mem_store  in  1  access is a store (valid when ex_mem_en = 1)
- ex_ld_type  in  3  load type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWU, 110 LD (LD legal only when DATA_W = 64)
- ex_addr_ofs  in  OFS_W  low address bits of the access
- ex_rf_we, ex_rf_waddr, ex_result  in  1/RA_W/DATA_W  GPR writeback intent and ALU result
- ex_hilo_we, ex_hi, ex_lo  in  2/32/32  HI/LO write enables ({hi,lo}) and values, passed through unchanged
- data_sram_rdata  in  DATA_W  read data; valid when data_sram_rvalid = 1
- data_sram_rvalid  in  1  response/ack for the outstanding access (loads and stores)
- stallreq_mem  out  1  stage requests a pipeline stall
- wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata  out  32/1/RA_W/DATA_W  to WB
- wb_hilo_we, wb_hi, wb_lo  out  2/32/32  to WB
- fwd_rf_we, fwd_rf_waddr, fwd_rf_wdata  out  1/RA_W/DATA_W  forwarding to ID
- fwd_load_pending  out  1  fwd_rf_wdata is not yet valid; ID must stall on a match

## Operation
- Input register, at each clk edge, in priority order:
  - rst: clear.
  - state = WAIT and data_sram_rvalid = 0: hold, whatever the stall bus says.
  - stall[STAGE] = 1 and stall[STAGE+1] = 0: load a bubble (all fields 0).
  - stall[STAGE] = 0: capture the ex_* inputs.
  - Otherwise: hold.
- FSM states: IDLE, WAIT, DONE.
  - On capture with ex_mem_en = 1 → WAIT; on any other capture or on a bubble → IDLE.
  - In WAIT, when data_sram_rvalid = 1 → DONE, and data_sram_rdata is latched into the load buffer.
  - DONE holds until the next capture or bubble.
  - data_sram_rvalid in IDLE or DONE is ignored.
- stallreq_mem = (state == WAIT) & ~data_sram_rvalid; combinational.
- Raw load data is data_sram_rdata when in WAIT, otherwise the load buffer.
- Load extraction, little-endian, using the lane selected by ex_addr_ofs:
  - LB and LH sign-extend to DATA_W; LBU and LHU zero-extend.
  - LW on DATA_W = 64 selects the word by ofs[2] and sign-extends; LWU zero-extends.
  - LD takes the full word.
  - Halfword lane uses ofs[OFS_W-1:1] (ofs[0] ignored); word lane ignores ofs[1:0].
- rf_wdata is the extracted load data when (mem_en & ~store), else ex_result.
- wb_rf_we = rf_we & ~stallreq_mem; wb_hilo_we = hilo_we & {2{~stallreq_mem}}.
- fwd_rf_we = rf_we; fwd_load_pending = stallreq_mem & rf_we.
- Stores write nothing back; they still wait for their ack.

## Timing
- Reset: all registers 0, state IDLE; every output 0.
- Outputs are combinational from the stage register, the load buffer, data_sram_rdata and data_sram_rvalid.
- Zero-wait SRAM: data_sram_rvalid = 1 in the first cycle after capture → no stall; the result reaches WB one cycle after capture.
- N-cycle response: stallreq_mem is high for N cycles after capture. It drops in the cycle data_sram_rvalid rises, and the data is usable that same cycle.
- The stall controller answers stallreq_mem with stall[STAGE+1:0] = Stop.
- Response arrives while an external stall holds the stage: the data is buffered (DONE) and presented until the stage advances.
- Reset during WAIT: returns to IDLE; a late data_sram_rvalid is ignored.

## Test plan
- Zero-wait LW, DATA_W = 32, ex_rf_waddr = 8, data_sram_rdata = 0x8000_00F0, rvalid in the cycle after capture → stallreq_mem never rises; wb_rf_wdata = 0x8000_00F0, wb_rf_we = 1.
- LB/LBU/LH/LHU with data_sram_rdata = 0x80FF_7F01:
  - LB, ofs 2 → 0xFFFF_FFFF; LBU, ofs 2 → 0x0000_00FF.
  - LH, ofs 2 → 0xFFFF_80FF; LHU, ofs 0 → 0x0000_7F01.
- 3-cycle load with rvalid low for 3 cycles → stallreq_mem and fwd_load_pending high for exactly 3 cycles, wb_rf_we = 0 during them; input register unchanged despite stall[STAGE] = 0 on the bench.
- DATA_W = 64, rdata = 0xFFFF_FFFE_0000_0001:
  - LW, ofs 4 → 0xFFFF_FFFF_FFFF_FFFE.
  - LWU, ofs 4 → 0x0000_0000_FFFF_FFFE.
  - LD → full value.
- Bubble (stall[3] = 1, stall[4] = 0) and external hold in DONE:
  - Bubble → all wb_*/fwd_* outputs 0.
  - External hold in DONE → buffered data stable while data_sram_rdata changes.
- rst asserted mid-WAIT, then a stray rvalid → outputs 0 immediately, state IDLE, stray response ignored.
